// File: rtl/cr_kme_drng_seed_loader.sv
// ---------------------------------------------------------------------------
// cr_kme_drng_seed_loader
//   Collects NUM_WORDS entropy words into a 384-bit DRNG seed, runs a
//   repetition test on consecutive accepted words, holds the finished seed
//   until the DRNG reports expiry, then issues a one-cycle start pulse.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   ent_valid/ent_data: entropy word stream, ent_ready = loader accepts
//   cfg_seed_life     : reseed interval latched alongside each seed
//   seed_expired      : DRNG request for a new seed (honoured in FULL only)
//   start             : one-cycle seed-load pulse
//   seed, seed_life   : assembled seed and its latched life
//   seed_ready        : a complete seed is held, not yet issued
//   rep_err           : one-cycle pulse on a repetition failure
//   rep_err_cnt       : saturating repetition-failure count
//   seed_cnt          : saturating issued-seed count
// ---------------------------------------------------------------------------
module cr_kme_drng_seed_loader #(
  parameter int unsigned ENT_W     = 32,
  parameter int unsigned NUM_WORDS = 12,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ent_valid,
  input  logic [ENT_W-1:0]             ent_data,
  output logic                         ent_ready,
  input  logic [47:0]                  cfg_seed_life,
  input  logic                         seed_expired,
  output logic                         start,
  output logic [NUM_WORDS*ENT_W-1:0]   seed,
  output logic [47:0]                  seed_life,
  output logic                         seed_ready,
  output logic                         rep_err,
  output logic [CNT_W-1:0]             rep_err_cnt,
  output logic [CNT_W-1:0]             seed_cnt
);

  localparam int unsigned SEED_W = NUM_WORDS * ENT_W;
  localparam int unsigned IDX_W  = 4;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] FULL    = 2'd1;
  localparam logic [1:0] ISSUE   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [ENT_W-1:0] prev_word;

  logic accept_c;
  logic rep_fail_c;
  logic keep_c;
  logic last_word_c;

  // Handshake qualification and repetition test on the incoming word.
  always_comb begin
    accept_c    = ent_valid & ent_ready;
    rep_fail_c  = accept_c && (idx != '0) && (ent_data == prev_word);
    keep_c      = accept_c && !rep_fail_c;
    last_word_c = keep_c && (idx == IDX_W'(NUM_WORDS - 1));
  end

  // Next-state and word-index logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      COLLECT: begin
        if (rep_fail_c) begin
          idx_nxt = '0;
        end else if (last_word_c) begin
          state_nxt = FULL;
          idx_nxt   = '0;
        end else if (keep_c) begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      FULL: begin
        if (seed_expired) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = COLLECT;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = COLLECT;
        idx_nxt   = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Registered Moore flags, seed assembly and statistics.
  // Flags decode state_nxt so they line up with the state register;
  // ent_ready is additionally held low for the whole reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_ready   <= 1'b0;
      seed_ready  <= 1'b0;
      start       <= 1'b0;
      rep_err     <= 1'b0;
      rep_err_cnt <= '0;
      seed_cnt    <= '0;
      seed        <= '0;
      seed_life   <= '0;
      prev_word   <= '0;
    end else begin
      ent_ready  <= (state_nxt == COLLECT);
      seed_ready <= (state_nxt == FULL);
      start      <= (state_nxt == ISSUE);
      rep_err    <= rep_fail_c;

      if (rep_fail_c && (rep_err_cnt != '1)) rep_err_cnt <= rep_err_cnt + CNT_W'(1);
      if ((state == ISSUE) && (seed_cnt != '1)) seed_cnt <= seed_cnt + CNT_W'(1);

      if (last_word_c) seed_life <= cfg_seed_life;
      if (keep_c)      prev_word <= ent_data;

      // Word k lands at the k-th slot from the MSB end.
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        if (keep_c && (idx == IDX_W'(k))) begin
          seed[SEED_W-1-k*ENT_W -: ENT_W] <= ent_data;
        end
      end
    end
  end

endmodule
